// File: rtl/bp_stall_hist_ctrl.sv
// Stall-reason histogram: coalesces per-cycle stall samples, accumulates them in a counter array, serves host reads.
// Latency: read data one cycle after rd_ready_o; a flushed sample lands in the array two cycles after its flush.
// Backpressure: host waits while a flush is pending, up to starve_lim_p cycles; a forced grant drops the sample. Define BP_STALL_HIST_SAT_EN to saturate counters.
module bp_stall_hist_ctrl #(
    parameter int num_reasons_p   = 32,
    parameter int cnt_width_p     = 32,
    parameter int pend_width_p    = 8,
    parameter int starve_lim_p    = 4,
    parameter int reason_width_lp = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_li,
    input  logic                       en_i,
    input  logic                       instret_i,
    input  logic                       reason_v_i,
    input  logic [reason_width_lp-1:0] reason_i,
    input  logic                       clear_i,
    output logic                       busy_o,
    input  logic                       rd_v_i,
    input  logic [reason_width_lp-1:0] rd_addr_i,
    output logic                       rd_ready_o,
    output logic                       rd_data_v_o,
    output logic [cnt_width_p-1:0]     rd_data_o,
    output logic [cnt_width_p-1:0]     instr_cnt_o,
    output logic [cnt_width_p-1:0]     dropped_cnt_o
);

    localparam int wait_width_lp = (starve_lim_p > 0) ? $clog2(starve_lim_p + 1) : 1;
    localparam logic [reason_width_lp:0]   lp_num_reasons = (reason_width_lp + 1)'(num_reasons_p);
    localparam logic [reason_width_lp-1:0] lp_last_idx    = reason_width_lp'(num_reasons_p - 1);
    localparam logic [wait_width_lp-1:0]   lp_starve_lim  = wait_width_lp'(starve_lim_p);

    typedef enum logic {
        e_clear,
        e_run
    } state_e;

    function automatic logic [cnt_width_p-1:0] f_add(input logic [cnt_width_p-1:0] a,
                                                     input logic [cnt_width_p-1:0] b);
`ifdef BP_STALL_HIST_SAT_EN
        logic [cnt_width_p:0] s;
        s = {1'b0, a} + {1'b0, b};
        f_add = s[cnt_width_p] ? '1 : s[cnt_width_p-1:0];
`else
        f_add = a + b;
`endif
    endfunction

    state_e                      r_state, w_state_n;
    logic [reason_width_lp-1:0]  r_sweep;
    logic                        r_pend_v;
    logic [reason_width_lp-1:0]  r_pend_reason;
    logic [pend_width_p-1:0]     r_pend_cnt;
    logic [wait_width_lp-1:0]    r_wait;
    logic                        r_w_v;
    logic [reason_width_lp-1:0]  r_w_addr;
    logic [cnt_width_p-1:0]      r_w_data;
    logic                        r_rd_data_v;
    logic [cnt_width_p-1:0]      r_rd_data;
    logic [cnt_width_p-1:0]      r_instr;
    logic [cnt_width_p-1:0]      r_dropped;
    logic [cnt_width_p-1:0]      r_mem [num_reasons_p];

    logic                        w_run, w_active, w_sample, w_match, w_flush_needed;
    logic                        w_grant, w_forced, w_flush, w_accept, w_addr_ok, w_hit;
    logic [reason_width_lp-1:0]  w_rd_addr;
    logic [cnt_width_p-1:0]      w_arr, w_pend_ext, w_rd_sum;

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) r_state <= e_clear;
        else           r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_run     = 1'b0;
        busy_o    = 1'b0;
        case (r_state)
            e_clear: begin
                busy_o = 1'b1;
                if (!clear_i && r_sweep == lp_last_idx) w_state_n = e_run;
            end
            e_run: begin
                w_run = 1'b1;
                if (clear_i) w_state_n = e_clear;
            end
            default: w_state_n = e_clear;
        endcase
    end

    // A clear in the same cycle as a request always wins.
    assign w_active       = w_run & ~clear_i;
    assign w_sample       = en_i & ~instret_i & reason_v_i;
    assign w_match        = r_pend_v & (r_pend_reason == reason_i) & ~(&r_pend_cnt);
    assign w_flush_needed = w_sample & r_pend_v & ~w_match;
    assign w_grant        = w_active & rd_v_i & (~w_flush_needed | (r_wait == lp_starve_lim));
    assign w_forced       = w_grant & w_flush_needed;
    assign w_flush        = w_active & w_flush_needed & ~w_grant;
    assign w_accept       = w_active & w_sample & ~w_forced;

    // The single read port serves either the host or the flush; the W stage is forwarded.
    assign w_rd_addr  = w_grant ? rd_addr_i : r_pend_reason;
    assign w_addr_ok  = {1'b0, w_rd_addr} < lp_num_reasons;
    assign w_arr      = !w_addr_ok ? '0 :
                        (r_w_v && r_w_addr == w_rd_addr) ? r_w_data : r_mem[w_rd_addr];
    assign w_pend_ext = cnt_width_p'(r_pend_cnt);
    assign w_hit      = r_pend_v & (r_pend_reason == rd_addr_i);
    assign w_rd_sum   = w_addr_ok ? f_add(w_arr, w_hit ? w_pend_ext : '0) : '0;

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            r_sweep       <= '0;
            r_pend_v      <= 1'b0;
            r_pend_reason <= '0;
            r_pend_cnt    <= '0;
            r_wait        <= '0;
            r_w_v         <= 1'b0;
            r_w_addr      <= '0;
            r_w_data      <= '0;
            r_rd_data_v   <= 1'b0;
            r_rd_data     <= '0;
            r_instr       <= '0;
            r_dropped     <= '0;
        end else begin
            r_sweep <= (clear_i || w_run) ? '0 : r_sweep + reason_width_lp'(1);

            if (!w_active) begin
                r_pend_v   <= 1'b0;
                r_pend_cnt <= '0;
            end else if (w_accept) begin
                if (w_match) begin
                    r_pend_cnt <= r_pend_cnt + pend_width_p'(1);
                end else begin
                    r_pend_v      <= 1'b1;
                    r_pend_reason <= reason_i;
                    r_pend_cnt    <= pend_width_p'(1);
                end
            end

            r_w_v <= w_flush;
            if (w_flush) begin
                r_w_addr <= r_pend_reason;
                r_w_data <= f_add(w_arr, w_pend_ext);
            end

            r_rd_data_v <= w_grant;
            if (w_grant) r_rd_data <= w_rd_sum;

            if (w_grant)                                 r_wait <= '0;
            else if (rd_v_i && r_wait != lp_starve_lim)  r_wait <= r_wait + wait_width_lp'(1);

            if (clear_i)                       r_instr <= '0;
            else if (w_run && en_i && instret_i) r_instr <= f_add(r_instr, cnt_width_p'(1));

            if (clear_i)       r_dropped <= '0;
            else if (w_forced) r_dropped <= f_add(r_dropped, cnt_width_p'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == e_clear) r_mem[r_sweep]  <= '0;
        else if (r_w_v)         r_mem[r_w_addr] <= r_w_data;
    end

    assign rd_ready_o    = w_grant;
    assign rd_data_v_o   = r_rd_data_v;
    assign rd_data_o     = r_rd_data;
    assign instr_cnt_o   = r_instr;
    assign dropped_cnt_o = r_dropped;

endmodule

// File: tb/tb_bp_stall_hist_ctrl.sv
// Directed bench for bp_stall_hist_ctrl: a 32-bit instance plus an 8-bit instance sharing all stimulus.
module tb_bp_stall_hist_ctrl;
    localparam int RW = 5;

    logic          clk_i = 1'b0;
    logic          reset_li = 1'b0;
    logic          en_i = 1'b0, instret_i = 1'b0, reason_v_i = 1'b0, clear_i = 1'b0, rd_v_i = 1'b0;
    logic [RW-1:0] reason_i = '0, rd_addr_i = '0;
    logic          busy_o, rd_ready_o, rd_data_v_o;
    logic [31:0]   rd_data_o, instr_cnt_o, dropped_cnt_o;
    logic          busy8, rdy8, dv8;
    logic [7:0]    data8, instr8, drop8;

    int            checks = 0;
    int            errors = 0;
    int            last_wait;
    logic [7:0]    last_d8;
    logic          last_dv8;

    bp_stall_hist_ctrl u_dut (
        .clk_i(clk_i), .reset_li(reset_li), .en_i(en_i), .instret_i(instret_i),
        .reason_v_i(reason_v_i), .reason_i(reason_i), .clear_i(clear_i), .busy_o(busy_o),
        .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
        .rd_data_v_o(rd_data_v_o), .rd_data_o(rd_data_o),
        .instr_cnt_o(instr_cnt_o), .dropped_cnt_o(dropped_cnt_o)
    );

    bp_stall_hist_ctrl #(.cnt_width_p(8)) u_dut8 (
        .clk_i(clk_i), .reset_li(reset_li), .en_i(en_i), .instret_i(instret_i),
        .reason_v_i(reason_v_i), .reason_i(reason_i), .clear_i(clear_i), .busy_o(busy8),
        .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rdy8),
        .rd_data_v_o(dv8), .rd_data_o(data8),
        .instr_cnt_o(instr8), .dropped_cnt_o(drop8)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 400000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_sample(input logic rv, input logic [RW-1:0] r, input logic ir);
        en_i       = 1'b1;
        reason_v_i = rv;
        reason_i   = r;
        instret_i  = ir;
    endtask

    task automatic idle();
        en_i       = 1'b0;
        reason_v_i = 1'b0;
        instret_i  = 1'b0;
    endtask

    // Request a read, wait (bounded) for the grant, return the data cycle's value.
    task automatic host_read(input logic [RW-1:0] a, output logic [31:0] d);
        int waited;
        waited    = 0;
        rd_v_i    = 1'b1;
        rd_addr_i = a;
        #1;
        while (!rd_ready_o && waited < 50) begin
            @(posedge clk_i);
            #2;
            waited++;
        end
        last_wait = waited;
        @(posedge clk_i);
        #1;
        rd_v_i = 1'b0;
        #1;
        chk("rd_data_v", 32'(rd_data_v_o), 32'd1);
        d        = rd_data_o;
        last_d8  = data8;
        last_dv8 = dv8;
    endtask

    initial begin
        logic [31:0] d, d1, d2;
        int          n, gidx, rdy_seen;

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_busy", 32'(busy_o), 32'd1);
        chk("reset_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("reset_rd_data_v", 32'(rd_data_v_o), 32'd0);
        chk("reset_rd_data", rd_data_o, 32'd0);
        chk("reset_instr", instr_cnt_o, 32'd0);
        chk("reset_dropped", dropped_cnt_o, 32'd0);

        reset_li = 1'b1;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            cyc();
        end
        chk("init_busy_cycles", n, 32'd32);

        host_read(5'd5, d);
        chk("rd5_value", d, 32'd0);
        chk("rd5_grant_wait", last_wait, 32'd0);
        cyc();
        chk("rd_data_v_one_cycle", 32'(rd_data_v_o), 32'd0);

        // 10 x reason 3, then reason 7 flushes 3; read right away exercises W forwarding
        for (int i = 0; i < 10; i++) begin
            set_sample(1'b1, 5'd3, 1'b0);
            cyc();
        end
        set_sample(1'b1, 5'd7, 1'b0);
        cyc();
        idle();
        host_read(5'd3, d);
        chk("rd3_after_flush", d, 32'd10);
        host_read(5'd7, d);
        chk("rd7_pending", d, 32'd1);

        // Alternating reasons with a held request: forced grant on the fifth request cycle
        gidx = -1;
        rd_v_i = 1'b1;
        rd_addr_i = 5'd1;
        for (int i = 0; i < 10 && gidx < 0; i++) begin
            set_sample(1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, 1'b0);
            #1;
            if (rd_ready_o) gidx = i;
            @(posedge clk_i);
            #1;
        end
        idle();
        rd_v_i = 1'b0;
        #1;
        chk("starve_grant_cycle", gidx, 32'd4);
        chk("starve_rd_data_v", 32'(rd_data_v_o), 32'd1);
        d1 = rd_data_o;
        chk("starve_rd1", d1, 32'd2);
        chk("starve_dropped", dropped_cnt_o, 32'd1);
        host_read(5'd2, d2);
        chk("starve_sum", d1 + d2, 32'd4);

        // 20 samples, then clear while samples and a read request keep coming
        for (int i = 0; i < 20; i++) begin
            set_sample(1'b1, 5'd4, 1'b0);
            cyc();
        end
        clear_i = 1'b1;
        rd_v_i = 1'b1;
        rd_addr_i = 5'd4;
        #1;
        chk("clear_beats_grant", 32'(rd_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        n = 0;
        rdy_seen = 0;
        while (busy_o && n < 100) begin
            n++;
            if (rd_ready_o) rdy_seen++;
            cyc();
        end
        idle();
        rd_v_i = 1'b0;
        chk("clear_busy_cycles", n, 32'd32);
        chk("clear_no_grant", rdy_seen, 32'd0);
        chk("clear_dropped", dropped_cnt_o, 32'd0);
        host_read(5'd4, d);
        chk("clear_rd4", d, 32'd0);
        host_read(5'd3, d);
        chk("clear_rd3", d, 32'd0);
        host_read(5'd1, d);
        chk("clear_rd1", d, 32'd0);

        // 300 samples of reason 0: 8-bit instance wraps or saturates
        for (int i = 0; i < 300; i++) begin
            set_sample(1'b1, 5'd0, 1'b0);
            cyc();
        end
        idle();
        host_read(5'd0, d);
        chk("rd0_300_w32", d, 32'd300);
        chk("rd0_300_w8_valid", 32'(last_dv8), 32'd1);
`ifdef BP_STALL_HIST_SAT_EN
        chk("rd0_300_w8", 32'(last_d8), 32'd255);
`else
        chk("rd0_300_w8", 32'(last_d8), 32'd44);
`endif
        chk("w8_busy", 32'(busy8), 32'd0);
        chk("w8_dropped", 32'(drop8), 32'd0);

        // instret masks the stall reason
        for (int i = 0; i < 6; i++) begin
            set_sample(1'b1, 5'd9, 1'b1);
            cyc();
        end
        idle();
        chk("instr_cnt", instr_cnt_o, 32'd6);
        chk("instr_cnt_w8", 32'(instr8), 32'd6);
        host_read(5'd9, d);
        chk("instret_rd9", d, 32'd0);
        host_read(5'd0, d);
        chk("rd0_kept", d, 32'd300);

        // Reset mid-operation restarts the sweep and wipes the array
        reset_li = 1'b0;
        #1;
        chk("rst2_busy", 32'(busy_o), 32'd1);
        chk("rst2_instr", instr_cnt_o, 32'd0);
        cyc();
        reset_li = 1'b1;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            cyc();
        end
        chk("rst2_busy_cycles", n, 32'd32);
        host_read(5'd0, d);
        chk("rst2_rd0", d, 32'd0);
        chk("rst2_rd0_w8", 32'(last_d8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
